// File: rtl/scarv_soc_reset_pkg.sv
// Shared types and constants for the SoC reset-request controller.
// Pure declarations: no logic, no latency, no flow control.
package scarv_soc_reset_pkg;

  typedef enum logic [2:0] {
    RC_IDLE,
    RC_PULSE,
    RC_WAIT_LOW,
    RC_WAIT_HIGH,
    RC_HOLDOFF
  } rc_state_t;

  localparam int REQ_SW  = 0;
  localparam int REQ_WDT = 1;
  localparam int REQ_DBG = 2;
  localparam int REQ_EXT = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/scarv_soc_prio_enc.sv
// Fixed-priority picker: lowest set bit wins, emitted as one-hot plus binary index.
// Purely combinational, zero latency; no backpressure.
module scarv_soc_prio_enc #(
  parameter  int W  = 4,
  localparam int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  in_vec,
  output logic [W-1:0]  onehot,
  output logic [IW-1:0] idx
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    onehot = '0;
    idx    = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (in_vec[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IW'(i);
      end
    end
  end

endmodule

// File: rtl/scarv_soc_reset_ctrl.sv
// Arbitrates reset requests into a fixed-width sys_reset pulse, tracks the CCX reset, then holds off.
// Grant-to-sys_reset is one edge; requests are ignored (not queued) whenever the FSM is busy.
module scarv_soc_reset_ctrl
  import scarv_soc_reset_pkg::*;
#(
  parameter int NREQ           = 4,
  parameter int PULSE_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int HOLDOFF_CYCLES = 64
) (
  input  logic                    f_clk,
  input  logic                    g_resetn,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         req_en,
  input  logic                    resetn_ccx_obs,
  input  logic                    status_clr,
  output logic                    sys_reset,
  output logic                    busy,
  output logic [NREQ-1:0]         cause,
  output logic [$clog2(NREQ)-1:0] last_id,
  output logic [7:0]              reset_count,
  output logic                    err_timeout
);

  localparam int IW      = $clog2(NREQ);
  localparam int CNT_MAX = max3(PULSE_CYCLES, TIMEOUT_CYCLES, HOLDOFF_CYCLES);
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] PULSE_LD   = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LD = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] HOLDOFF_LD = CW'(HOLDOFF_CYCLES - 1);

  rc_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] req_m;
  logic [NREQ-1:0] grant_oh;
  logic [IW-1:0]   grant_idx;
  logic            grant;
  logic            timeout;
  logic            cnt_zero;

  assign req_m    = req & req_en;
  assign cnt_zero = (cnt_q == '0);
  assign busy     = (state_q != RC_IDLE);

  scarv_soc_prio_enc #(.W(NREQ)) u_prio (
    .in_vec (req_m),
    .onehot (grant_oh),
    .idx    (grant_idx)
  );

  // One shared down-counter: loaded with N-1 on state entry, state exits when it reaches 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant   = 1'b0;
    timeout = 1'b0;
    unique case (state_q)
      RC_IDLE: begin
        if (|grant_oh) begin
          grant   = 1'b1;
          state_d = RC_PULSE;
          cnt_d   = PULSE_LD;
        end
      end
      RC_PULSE: begin
        if (cnt_zero) begin
          state_d = RC_WAIT_LOW;
          cnt_d   = TIMEOUT_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RC_WAIT_LOW: begin
        if (!resetn_ccx_obs) begin
          state_d = RC_WAIT_HIGH;
          cnt_d   = TIMEOUT_LD;
        end else if (cnt_zero) begin
          timeout = 1'b1;
          state_d = RC_HOLDOFF;
          cnt_d   = HOLDOFF_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RC_WAIT_HIGH: begin
        if (resetn_ccx_obs) begin
          state_d = RC_HOLDOFF;
          cnt_d   = HOLDOFF_LD;
        end else if (cnt_zero) begin
          timeout = 1'b1;
          state_d = RC_HOLDOFF;
          cnt_d   = HOLDOFF_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RC_HOLDOFF: begin
        if (cnt_zero) begin
          state_d = RC_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = RC_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge f_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q   <= RC_IDLE;
      cnt_q     <= '0;
      sys_reset <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sys_reset <= (state_d == RC_PULSE);
    end
  end

  // Clear is applied before a same-cycle grant or timeout, so new events survive it.
  always_ff @(posedge f_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      cause       <= '0;
      last_id     <= '0;
      reset_count <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (status_clr) begin
        cause       <= '0;
        reset_count <= '0;
        err_timeout <= 1'b0;
      end
      if (grant) begin
        last_id     <= grant_idx;
        cause       <= (status_clr ? '0 : cause) | req_m;
        reset_count <= status_clr ? 8'd1
                     : (reset_count == 8'hFF) ? 8'hFF : reset_count + 8'd1;
      end
      if (timeout) begin
        err_timeout <= 1'b1;
      end
    end
  end

endmodule
